// File: rtl/multdiv_pkg.sv
// Shared types and width-independent constants for the iterative multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] OP_MUL     = 2'd0;
  localparam logic [1:0] OP_DIV     = 2'd1;
  localparam logic [1:0] OP_ILLEGAL = 2'd2;

  localparam int unsigned TAG_W_DEF = 5;

  // Iteration counter width: enough to count WIDTH steps with one bit of headroom.
  function automatic int unsigned cnt_w(input int unsigned w);
    return 32'($clog2(w)) + 32'd1;
  endfunction

endpackage

// File: rtl/twos_abs.sv
// Conditional two's-complement negate; yields the magnitude when neg_i is the sign bit.
module twos_abs #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_c_o
);

  // Negate when requested; MIN maps onto itself, which is the correct unsigned magnitude.
  always_comb begin
    res_c_o = neg_i ? (~val_i + W'(1)) : val_i;
  end

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed shift-add multiply / restoring divide with tagged completion strobe.
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [TAG_W-1:0] tag_in,
  output logic             busy,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned CNT_W = cnt_w(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_q, neg_d;
  logic               pend_q, pend_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               busy_q, busy_d;
  logic               rdy_q, rdy_d;
  logic               exc_q, exc_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [TAG_W-1:0]   tag_out_q, tag_out_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [1:0]         op;
  logic               start;
  logic               last;
  logic [WIDTH:0]     mul_sum;
  logic [W2-1:0]      mul_next;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [W2-1:0]      div_next;
  logic [W2-1:0]      fix_in, fix_out;
  logic               mul_ovf, div_ovf;

  twos_abs #(.W(WIDTH)) u_abs_a (
    .val_i   (data_operandA),
    .neg_i   (data_operandA[WIDTH-1]),
    .res_c_o (a_mag)
  );

  twos_abs #(.W(WIDTH)) u_abs_b (
    .val_i   (data_operandB),
    .neg_i   (data_operandB[WIDTH-1]),
    .res_c_o (b_mag)
  );

  twos_abs #(.W(W2)) u_fix (
    .val_i   (fix_in),
    .neg_i   (neg_q),
    .res_c_o (fix_out)
  );

  // Start decode and one iteration step of each datapath; acc holds {partial, multiplier} or {remainder, quotient}.
  always_comb begin
    start    = ctrl_MULT | ctrl_DIV;
    op       = (ctrl_MULT & ctrl_DIV) ? OP_ILLEGAL : (ctrl_MULT ? OP_MUL : OP_DIV);
    last     = (cnt_q == CNT_W'(WIDTH - 1));
    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    div_ge   = ~div_diff[WIDTH];
    div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    fix_in   = (state_q == MUL) ? mul_next : {WIDTH'(0), div_next[WIDTH-1:0]};
    mul_ovf  = ~((&fix_out[W2-1:WIDTH-1]) | ~(|fix_out[W2-1:WIDTH-1]));
    div_ovf  = ~neg_q & div_next[WIDTH-1];
  end

  // Next-state and datapath update; error starts wait one cycle in IDLE so the strobe lands after edge 1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    pend_d    = 1'b0;
    tag_d     = tag_q;
    res_d     = res_q;
    exc_d     = exc_q;
    tag_out_d = tag_out_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (pend_q) begin
          state_d   = DONE;
          res_d     = '0;
          exc_d     = 1'b1;
          tag_out_d = tag_q;
        end else if (start) begin
          tag_d = tag_in;
          cnt_d = '0;
          neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          if ((op == OP_ILLEGAL) || ((op == OP_DIV) && (data_operandB == '0))) begin
            pend_d = 1'b1;
          end else if (op == OP_MUL) begin
            state_d = MUL;
            opnd_d  = a_mag;
            acc_d   = {WIDTH'(0), b_mag};
          end else begin
            state_d = DIV;
            opnd_d  = b_mag;
            acc_d   = {WIDTH'(0), a_mag};
          end
        end
      end
      MUL, DIV: begin
        acc_d = (state_q == MUL) ? mul_next : div_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          state_d   = DONE;
          res_d     = fix_out[WIDTH-1:0];
          exc_d     = (state_q == MUL) ? mul_ovf : div_ovf;
          tag_out_d = tag_q;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MUL) || (state_d == DIV);
    rdy_d  = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      pend_q    <= 1'b0;
      tag_q     <= '0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
      exc_q     <= 1'b0;
      res_q     <= '0;
      tag_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      pend_q    <= pend_d;
      tag_q     <= tag_d;
      busy_q    <= busy_d;
      rdy_q     <= rdy_d;
      exc_q     <= exc_d;
      res_q     <= res_d;
      tag_out_q <= tag_out_d;
    end
  end

  assign busy           = busy_q;
  assign data_resultRDY = rdy_q;
  assign data_exception = exc_q;
  assign data_result    = res_q;
  assign tag_out        = tag_out_q;

endmodule

// File: tb/tb_multdiv_iter.sv
// Self-checking bench for multdiv_iter at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_multdiv_iter;

  logic        clk;
  logic        rst_n;
  logic        mult_r, div_r;
  logic [31:0] a_r, b_r;
  logic [4:0]  tag_r;
  logic        sel8;

  logic        busy32, rdy32, exc32;
  logic [31:0] res32;
  logic [4:0]  tag32;
  logic        busy8, rdy8, exc8;
  logic [7:0]  res8;
  logic [4:0]  tag8;

  logic        busy_v, rdy_v, exc_v;
  logic [31:0] res_v;
  logic [4:0]  tag_v;

  int n_tests = 0;
  int n_fail  = 0;

  multdiv_iter #(.WIDTH(32), .TAG_W(5)) dut32 (
    .clock          (clk),
    .reset          (rst_n),
    .ctrl_MULT      (mult_r & ~sel8),
    .ctrl_DIV       (div_r & ~sel8),
    .data_operandA  (a_r),
    .data_operandB  (b_r),
    .tag_in         (tag_r),
    .busy           (busy32),
    .data_result    (res32),
    .data_exception (exc32),
    .data_resultRDY (rdy32),
    .tag_out        (tag32)
  );

  multdiv_iter #(.WIDTH(8), .TAG_W(5)) dut8 (
    .clock          (clk),
    .reset          (rst_n),
    .ctrl_MULT      (mult_r & sel8),
    .ctrl_DIV       (div_r & sel8),
    .data_operandA  (a_r[7:0]),
    .data_operandB  (b_r[7:0]),
    .tag_in         (tag_r),
    .busy           (busy8),
    .data_result    (res8),
    .data_exception (exc8),
    .data_resultRDY (rdy8),
    .tag_out        (tag8)
  );

  assign busy_v = sel8 ? busy8 : busy32;
  assign rdy_v  = sel8 ? rdy8  : rdy32;
  assign exc_v  = sel8 ? exc8  : exc32;
  assign res_v  = sel8 ? {24'd0, res8} : res32;
  assign tag_v  = sel8 ? tag8  : tag32;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: interpret low w bits as signed, compute the exact product/quotient, then truncate.
  function automatic void model(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                                input int w, output logic [31:0] res, output bit exc, output bit err);
    logic [63:0] mask, tmp;
    longint sa, sb, r, lo, hi;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'({32'd0, a} & mask);
    sb = longint'({32'd0, b} & mask);
    if (a[w-1]) sa = sa - longint'(64'd1 << w);
    if (b[w-1]) sb = sb - longint'(64'd1 << w);
    lo = -longint'(64'd1 << (w - 1));
    hi = longint'(64'd1 << (w - 1)) - 1;
    if ((m && d) || (d && sb == 0)) begin
      res = 32'd0; exc = 1'b1; err = 1'b1;
    end else begin
      r   = m ? sa * sb : sa / sb;
      exc = (r < lo) || (r > hi);
      tmp = 64'(r) & mask;
      res = tmp[31:0];
      err = 1'b0;
    end
  endfunction

  // Drive a start at the current negedge; return at the negedge after the sampling edge.
  task automatic issue(input bit m, input bit d, input logic [31:0] a_x, input logic [31:0] b_x,
                       input logic [4:0] t);
    mult_r = m; div_r = d; a_r = a_x; b_r = b_x; tag_r = t;
    @(posedge clk);
    @(negedge clk);
    mult_r = 1'b0; div_r = 1'b0;
    a_r = $urandom; b_r = $urandom; tag_r = 5'($urandom);
  endtask

  // Follow an issued operation to its strobe, checking busy/strobe timing and the registered results.
  task automatic finish_op(input string name, input bit m, input bit d, input logic [31:0] a_x,
                           input logic [31:0] b_x, input logic [4:0] tag_x, input bit stop_at_rdy,
                           input int inject_at);
    logic [31:0] er;
    bit ee, err, seen;
    int lat, k, tbad;
    model(m, d, a_x, b_x, sel8 ? 8 : 32, er, ee, err);
    lat = err ? 1 : (sel8 ? 8 : 32);
    k = 0; tbad = 0; seen = 1'b0;
    while (!seen && k <= lat + 4) begin
      if (inject_at >= 0 && k == inject_at + 1) begin mult_r = 1'b0; div_r = 1'b0; end
      if (busy_v !== 1'(!err && k < lat)) tbad++;
      if (rdy_v === 1'b1) seen = 1'b1;
      else begin
        if (inject_at >= 0 && k == inject_at) begin
          div_r = 1'b1; a_r = $urandom; b_r = $urandom | 32'd1; tag_r = 5'($urandom);
        end
        @(negedge clk);
        k++;
      end
    end
    n_tests++;
    if (!seen || k != lat || tbad != 0) begin
      n_fail++;
      $display("FAIL %s timing: rdy seen=%0d at cycle %0d, busy errors %0d; required rdy at cycle %0d",
               name, seen, k, tbad, lat);
    end
    if (seen) begin
      n_tests++;
      if (res_v !== er) begin
        n_fail++; $display("FAIL %s result: got %h, required %h", name, res_v, er);
      end
      n_tests++;
      if (exc_v !== ee) begin
        n_fail++; $display("FAIL %s exception: got %b, required %b", name, exc_v, ee);
      end
      n_tests++;
      if (tag_v !== tag_x) begin
        n_fail++; $display("FAIL %s tag: got %0d, required %0d", name, tag_v, tag_x);
      end
    end
    if (!stop_at_rdy) begin
      @(negedge clk);
      n_tests++;
      if (rdy_v !== 1'b0 || res_v !== er || exc_v !== ee) begin
        n_fail++;
        $display("FAIL %s hold: rdy=%b res=%h exc=%b, required rdy=0 res=%h exc=%b",
                 name, rdy_v, res_v, exc_v, er, ee);
      end
    end
  endtask

  task automatic run(input string name, input bit m, input bit d, input logic [31:0] a_x,
                     input logic [31:0] b_x, input logic [4:0] t);
    issue(m, d, a_x, b_x, t);
    finish_op(name, m, d, a_x, b_x, t, 1'b0, -1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mult_r = 1'b0; div_r = 1'b0; a_r = '0; b_r = '0; tag_r = '0; sel8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy32, rdy32, exc32, res32, tag32} !== '0) begin
      n_fail++; $display("FAIL reset32: outputs %h, required 0", {busy32, rdy32, exc32, res32, tag32});
    end
    n_tests++;
    if ({busy8, rdy8, exc8, res8, tag8} !== '0) begin
      n_fail++; $display("FAIL reset8: outputs %h, required 0", {busy8, rdy8, exc8, res8, tag8});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [31:0] x, y;
    run("mul_7x-3", 1, 0, 32'd7, -32'sd3, 5'd5);
    run("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 5'd9);
    run("mul_min_x1", 1, 0, 32'h8000_0000, 32'd1, 5'd17);
    for (int i = 0; i < 6; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      y = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = -x;
      if ($urandom_range(0, 1) == 1) y = -y;
      run("mul_rand", 1, 0, x, y, 5'($urandom));
    end
  endtask

  task automatic test_div();
    logic [31:0] x, y;
    run("div_-7/2", 0, 1, -32'sd7, 32'd2, 5'd3);
    run("div_min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd30);
    run("div_by_zero", 0, 1, 32'd5, 32'd0, 5'd12);
    run("div_min/min", 0, 1, 32'h8000_0000, 32'h8000_0000, 5'd1);
    for (int i = 0; i < 6; i++) begin
      x = $urandom;
      y = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) y = -y;
      run("div_rand", 0, 1, x, y, 5'($urandom));
    end
  endtask

  task automatic test_illegal();
    run("illegal_both", 1, 1, $urandom, $urandom, 5'd22);
  endtask

  task automatic test_ignored_start();
    logic [31:0] x, y;
    int extra;
    x = $urandom; y = $urandom >> 16;
    issue(1, 0, x, y, 5'd7);
    finish_op("ignored_start", 1, 0, x, y, 5'd7, 1'b0, 10);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy_v !== 1'b0 || busy_v !== 1'b0) extra++;
    end
    n_tests++;
    if (extra != 0) begin
      n_fail++; $display("FAIL ignored_start extra activity: %0d cycles with rdy/busy, required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y;
    x = $urandom >> 8; y = -($urandom >> 12);
    issue(1, 0, x, y, 5'd11);
    finish_op("b2b_mul", 1, 0, x, y, 5'd11, 1'b1, -1);
    issue(0, 1, 32'd100, 32'd7, 5'd19);
    finish_op("b2b_div", 0, 1, 32'd100, 32'd7, 5'd19, 1'b0, -1);
  endtask

  task automatic test_reset_midop(input int at);
    int rdys;
    issue(1, 0, $urandom, $urandom, 5'd4);
    for (int k = 0; k < at; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy_v, rdy_v, exc_v, res_v, tag_v} !== '0) begin
      n_fail++; $display("FAIL reset_midop: outputs %h, required 0", {busy_v, rdy_v, exc_v, res_v, tag_v});
    end
    @(negedge clk);
    rst_n = 1'b1;
    rdys = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy_v !== 1'b0) rdys++;
    end
    n_tests++;
    if (rdys != 0) begin
      n_fail++; $display("FAIL reset_midop strobe: %0d strobes after reset, required 0", rdys);
    end
    run("after_reset_3x4", 1, 0, 32'd3, 32'd4, 5'd6);
  endtask

  task automatic test_width8();
    sel8 = 1'b1;
    run("w8_12x-11", 1, 0, 32'd12, 32'hFFFF_FFF5, 5'd2);
    run("w8_min/-1", 0, 1, 32'h80, 32'hFF, 5'd8);
    run("w8_div0", 0, 1, 32'h33, 32'h00, 5'd13);
    for (int i = 0; i < 4; i++) begin
      run("w8_mul_rand", 1, 0, $urandom, $urandom, 5'($urandom));
      run("w8_div_rand", 0, 1, $urandom, $urandom | 32'd1, 5'($urandom));
    end
    test_reset_midop(5);
    sel8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_illegal();
    test_ignored_start();
    test_back_to_back();
    test_reset_midop(15);
    test_width8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
